// File: rtl/mem_stage.sv
// Memory-access pipeline stage: multi-cycle word load/store against a local data
// memory, upstream freeze via mem_ready, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic [1:0]  mem_signal_in,
  input  logic [4:0]  dest_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] st_val_in,
  output logic        mem_ready,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [4:0]  dest_out,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic        addr_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [DEPTH];

  logic [31:0]   w_off;
  logic [31:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_req;
  logic          w_store;
  logic          w_load;
  logic          w_last;

  // Byte address -> word index; low two address bits are ignored
  assign w_off      = alu_result_in - 32'(BASE_ADDR);
  assign w_word     = w_off >> 2;
  assign w_idx      = w_word[AW-1:0];
  assign w_in_range = (alu_result_in >= 32'(BASE_ADDR)) && (w_word < 32'(DEPTH));

  // Both enables set is a store; the read request is dropped
  assign w_req   = |mem_signal_in;
  assign w_store = mem_signal_in[0];
  assign w_load  = mem_signal_in[1] & ~mem_signal_in[0];

  assign w_last    = (r_state == S_ACCESS) && (r_cnt == 4'(WAIT_CYCLES - 1));
  assign mem_ready = (r_state == S_IDLE) ? ~w_req : w_last;

  // Data array is not reset; a reset during ACCESS suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && w_last && w_store && w_in_range) begin
      r_mem[w_idx] <= st_val_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      dest_out       <= 5'd0;
      pc_out         <= 32'd0;
      alu_result_out <= 32'd0;
      mem_data_out   <= 32'd0;
      addr_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_ACCESS;
            r_cnt   <= 4'd0;
          end
        end
        S_ACCESS: begin
          if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // MEM/WB: retire when ready, otherwise insert a bubble and hold the payload
      if (mem_ready) begin
        wb_en_out      <= wb_en_in;
        mem_r_en_out   <= w_load;
        dest_out       <= dest_in;
        pc_out         <= pc_in;
        alu_result_out <= alu_result_in;
        mem_data_out   <= (w_load && w_in_range) ? r_mem[w_idx] : 32'd0;
        addr_err       <= w_req & ~w_in_range;
      end else begin
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops checked
// against a transaction-level memory model.
module tb_mem_stage;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned WAITC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in;
  logic [1:0]  mem_signal_in;
  logic [4:0]  dest_in;
  logic [31:0] pc_in;
  logic [31:0] alu_result_in;
  logic [31:0] st_val_in;
  logic        mem_ready;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [4:0]  dest_out;
  logic [31:0] pc_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data_out;
  logic        addr_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mdl [DEPTH];
  logic [4:0]  prev_dest;

  mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_signal_in(mem_signal_in), .dest_in(dest_in),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in),
    .mem_ready(mem_ready), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .dest_out(dest_out), .pc_out(pc_out), .alu_result_out(alu_result_out),
    .mem_data_out(mem_data_out), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".wb_en"},    32'(wb_en_out), 0);
    check({tag, ".mem_r_en"}, 32'(mem_r_en_out), 0);
    check({tag, ".dest"},     32'(dest_out), 0);
    check({tag, ".pc"},       pc_out, 0);
    check({tag, ".alu"},      alu_result_out, 0);
    check({tag, ".data"},     mem_data_out, 0);
    check({tag, ".addr_err"}, 32'(addr_err), 0);
  endtask

  // Issue one op at posedge+1 and follow it through to retirement
  task automatic run_op(input string tag, input logic [1:0] sig, input logic [31:0] addr,
                        input logic [31:0] sv, input logic wb, input logic [4:0] dst,
                        input logic [31:0] pc);
    int          stalls;
    bit          req, ld, st, ok;
    logic [31:0] exp_data;
    req = (sig != 2'b00);
    st  = sig[0];
    ld  = (sig == 2'b10);
    ok  = in_range(addr);
    exp_data = (ld && ok) ? mdl[(addr - BASE) >> 2] : 32'd0;

    wb_en_in = wb; mem_signal_in = sig; dest_in = dst;
    pc_in = pc; alu_result_in = addr; st_val_in = sv;
    #1;
    stalls = 0;
    while (mem_ready !== 1'b1 && stalls < 20) begin
      stalls++;
      @(posedge clk); #1;
      check({tag, ".bubble_wb"},   32'(wb_en_out), 0);
      check({tag, ".bubble_rd"},   32'(mem_r_en_out), 0);
      check({tag, ".bubble_dest"}, 32'(dest_out), 32'(prev_dest));
    end
    check({tag, ".stall_cycles"}, 32'(stalls), req ? WAITC : 0);
    @(posedge clk); #1;
    check({tag, ".wb_en"},    32'(wb_en_out), 32'(wb));
    check({tag, ".mem_r_en"}, 32'(mem_r_en_out), 32'(ld));
    check({tag, ".dest"},     32'(dest_out), 32'(dst));
    check({tag, ".pc"},       pc_out, pc);
    check({tag, ".alu"},      alu_result_out, addr);
    check({tag, ".data"},     mem_data_out, exp_data);
    check({tag, ".addr_err"}, 32'(addr_err), 32'(req && !ok));
    if (st && ok) mdl[(addr - BASE) >> 2] = sv;
    prev_dest = dst;
    mem_signal_in = 2'b00;
  endtask

  initial begin
    logic [1:0]  rsig;
    logic [31:0] raddr;
    rst = 1'b1; wb_en_in = 1'b0; mem_signal_in = 2'b00; dest_in = 5'd0;
    pc_in = 32'd0; alu_result_in = 32'd0; st_val_in = 32'd0;
    prev_dest = 5'd0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("reset.ready_idle", 32'(mem_ready), 1);

    // Preload every word so later loads have a known expected value
    for (int i = 0; i < int'(DEPTH); i++)
      run_op("preload", 2'b01, BASE + 32'(4 * i), $urandom(), 1'b0, 5'(i), 32'(i * 4));

    run_op("pass",  2'b00, 32'h55, 32'h0, 1'b1, 5'd5, 32'h100);
    run_op("st",    2'b01, 32'd1032, 32'h12345678, 1'b0, 5'd0, 32'h104);
    run_op("ld",    2'b10, 32'd1034, 32'h0, 1'b1, 5'd7, 32'h108);
    check("ld.value", mem_data_out, 32'h12345678);
    run_op("ld_lo", 2'b10, 32'd1020, 32'h0, 1'b1, 5'd8, 32'h10c);
    run_op("ld_hi", 2'b10, BASE + 4 * 63, 32'h0, 1'b1, 5'd9, 32'h110);
    run_op("st_oob", 2'b01, BASE + 4 * 64, 32'hCAFEF00D, 1'b0, 5'd0, 32'h114);
    run_op("ld_w0", 2'b10, BASE, 32'h0, 1'b1, 5'd10, 32'h118);
    run_op("ld_far", 2'b10, 32'h0000_0000, 32'h0, 1'b1, 5'd11, 32'h11c);

    for (int i = 0; i < 4; i++)
      run_op("b2b_st", 2'b01, BASE + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 5'd0, 32'h200 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      run_op("b2b_ld", 2'b10, BASE + 32'(4 * i), 32'h0, 1'b1, 5'(i + 1), 32'h300 + 32'(i));
      check("b2b_ld.value", mem_data_out, 32'hB0 + 32'(i));
    end

    run_op("both", 2'b11, 32'd1040, 32'hA5, 1'b0, 5'd3, 32'h400);
    run_op("both_ld", 2'b10, 32'd1040, 32'h0, 1'b1, 5'd4, 32'h404);
    check("both_ld.value", mem_data_out, 32'hA5);

    // Reset in the middle of a store: no write, no retire
    run_op("pre_abort", 2'b01, BASE, 32'h1111_1111, 1'b0, 5'd0, 32'h500);
    wb_en_in = 1'b0; mem_signal_in = 2'b01; dest_in = 5'd12;
    pc_in = 32'h504; alu_result_in = BASE; st_val_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    rst = 1'b1; mem_signal_in = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst = 1'b0;
    prev_dest = 5'd0;
    #1;
    check("abort.ready_idle", 32'(mem_ready), 1);
    run_op("post_abort", 2'b10, BASE, 32'h0, 1'b1, 5'd13, 32'h508);
    check("post_abort.value", mem_data_out, 32'h1111_1111);

    for (int i = 0; i < 200; i++) begin
      rsig = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) raddr = $urandom();
      else raddr = 32'($urandom_range(BASE - 16, BASE + 4 * DEPTH + 16));
      run_op("rand", rsig, raddr, $urandom(), 1'($urandom()), 5'($urandom()), $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
